// File: rtl/rob_pkg.sv
// Shared types and defaults for the reorder buffer.
package rob_pkg;

    localparam int ROB_DEPTH = 16;
    localparam int ROB_XLEN  = 32;

    typedef enum logic [1:0] {
        ROB_KIND_REG    = 2'd0,
        ROB_KIND_STORE  = 2'd1,
        ROB_KIND_BRANCH = 2'd2,
        ROB_KIND_JALR   = 2'd3
    } rob_kind_e;

    // Payload fields are sized by ROB_XLEN; the top-level XLEN must match it.
    typedef struct packed {
        logic                busy;
        logic                done;
        rob_kind_e           kind;
        logic [4:0]          rd;
        logic [ROB_XLEN-1:0] val;
        logic [ROB_XLEN-1:0] npc;
        logic [ROB_XLEN-1:0] pred_npc;
    } rob_entry_t;

endpackage

// File: rtl/rob_gen2_if.sv
// Bus between the reorder buffer and decode, writeback, regfile and LSB.
// master = surrounding pipeline, slave = reorder buffer.
interface rob_gen2_if
    import rob_pkg::*;
#(
    parameter int IDX_W  = 4,
    parameter int XLEN   = ROB_XLEN,
    parameter int NUM_WB = 2
) ();

    logic                     alloc_valid;
    logic                     alloc_ready;
    logic [IDX_W-1:0]         alloc_tag;
    logic [1:0]               alloc_kind;
    logic [4:0]               alloc_rd;
    logic                     alloc_done;
    logic [XLEN-1:0]          alloc_val;
    logic [XLEN-1:0]          alloc_pred_npc;

    logic [NUM_WB-1:0]        wb_valid;
    logic [NUM_WB*IDX_W-1:0]  wb_tag;
    logic [NUM_WB*XLEN-1:0]   wb_val;
    logic [NUM_WB*XLEN-1:0]   wb_npc;

    logic [IDX_W-1:0]         qa_tag;
    logic [IDX_W-1:0]         qb_tag;
    logic                     qa_ready;
    logic                     qb_ready;
    logic [XLEN-1:0]          qa_val;
    logic [XLEN-1:0]          qb_val;

    logic                     cmt_we;
    logic [4:0]               cmt_rd;
    logic [XLEN-1:0]          cmt_val;
    logic [IDX_W-1:0]         cmt_tag;
    logic                     cmt_store;
    logic [IDX_W-1:0]         cmt_store_tag;
    logic                     cmt_store_ack;

    logic                     flush;
    logic [XLEN-1:0]          flush_pc;
    logic [IDX_W:0]           count;

    modport master (
        output alloc_valid, alloc_kind, alloc_rd, alloc_done, alloc_val, alloc_pred_npc,
        output wb_valid, wb_tag, wb_val, wb_npc, qa_tag, qb_tag, cmt_store_ack,
        input  alloc_ready, alloc_tag, qa_ready, qb_ready, qa_val, qb_val,
        input  cmt_we, cmt_rd, cmt_val, cmt_tag, cmt_store, cmt_store_tag,
        input  flush, flush_pc, count
    );

    modport slave (
        input  alloc_valid, alloc_kind, alloc_rd, alloc_done, alloc_val, alloc_pred_npc,
        input  wb_valid, wb_tag, wb_val, wb_npc, qa_tag, qb_tag, cmt_store_ack,
        output alloc_ready, alloc_tag, qa_ready, qb_ready, qa_val, qb_val,
        output cmt_we, cmt_rd, cmt_val, cmt_tag, cmt_store, cmt_store_tag,
        output flush, flush_pc, count
    );

endinterface

// File: rtl/rob_wb_merge.sv
// Folds the writeback ports into one update per ROB entry; on a tag
// collision the highest-numbered port wins. Also feeds the query bypass.
module rob_wb_merge #(
    parameter int DEPTH  = 16,
    parameter int IDX_W  = $clog2(DEPTH),
    parameter int XLEN   = 32,
    parameter int NUM_WB = 2
) (
    input  logic [NUM_WB-1:0]            wb_valid,
    input  logic [NUM_WB*IDX_W-1:0]      wb_tag,
    input  logic [NUM_WB*XLEN-1:0]       wb_val,
    input  logic [NUM_WB*XLEN-1:0]       wb_npc,
    output logic [DEPTH-1:0]             upd_hit,
    output logic [DEPTH-1:0][XLEN-1:0]   upd_val,
    output logic [DEPTH-1:0][XLEN-1:0]   upd_npc
);

    // Ascending port scan so a later (higher) port overwrites an earlier one.
    always_comb begin
        // NOTE: every output gets a default before the loop, otherwise entries not hit would infer latches.
        upd_hit = '0;
        upd_val = '0;
        upd_npc = '0;
        for (int p = 0; p < NUM_WB; p++) begin
            if (wb_valid[p]) begin
                upd_hit[wb_tag[p*IDX_W +: IDX_W]] = 1'b1;
                upd_val[wb_tag[p*IDX_W +: IDX_W]] = wb_val[p*XLEN +: XLEN];
                upd_npc[wb_tag[p*IDX_W +: IDX_W]] = wb_npc[p*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/rob_gen2.sv
// Parametrised reorder buffer: in-order allocate, out-of-order writeback,
// in-order commit with store handshake and mispredict flush/redirect.
module rob_gen2
    import rob_pkg::*;
#(
    parameter int DEPTH  = ROB_DEPTH,
    parameter int IDX_W  = $clog2(DEPTH),
    parameter int XLEN   = ROB_XLEN,
    parameter int NUM_WB = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     rdy,
    rob_gen2_if.slave bus
);

    localparam int PTR_W = IDX_W + 1;

    rob_entry_t              ent_q [DEPTH];
    rob_entry_t              ent_d [DEPTH];
    logic [PTR_W-1:0]        head_q, head_d, tail_q, tail_d;
    logic                    flush_q, flush_d;
    logic [XLEN-1:0]         flush_pc_q, flush_pc_d;
    logic                    cmt_we_q, cmt_we_d;
    logic [4:0]              cmt_rd_q, cmt_rd_d;
    logic [XLEN-1:0]         cmt_val_q, cmt_val_d;
    logic [IDX_W-1:0]        cmt_tag_q, cmt_tag_d;

    logic [DEPTH-1:0]            upd_hit;
    logic [DEPTH-1:0][XLEN-1:0]  upd_val;
    logic [DEPTH-1:0][XLEN-1:0]  upd_npc;

    logic [PTR_W-1:0]  count;
    logic              empty, full, alloc_ready, cmt_store;
    logic [IDX_W-1:0]  head_idx, tail_idx;
    rob_entry_t        head_ent;
    logic              alloc_fire, retire, mispredict;

    assign count       = tail_q - head_q;
    assign empty       = (head_q == tail_q);
    assign full        = (count == PTR_W'(DEPTH));
    assign head_idx    = head_q[IDX_W-1:0];
    assign tail_idx    = tail_q[IDX_W-1:0];
    assign head_ent    = ent_q[head_idx];
    // Full is the registered view, so a same-cycle retire never frees a slot early.
    assign alloc_ready = !full && !flush_q;
    assign cmt_store   = !empty && head_ent.done && (head_ent.kind == ROB_KIND_STORE);

    rob_wb_merge #(
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W),
        .XLEN   (XLEN),
        .NUM_WB (NUM_WB)
    ) u_wb_merge (
        .wb_valid (bus.wb_valid),
        .wb_tag   (bus.wb_tag),
        .wb_val   (bus.wb_val),
        .wb_npc   (bus.wb_npc),
        .upd_hit  (upd_hit),
        .upd_val  (upd_val),
        .upd_npc  (upd_npc)
    );

    // Next state: writeback, allocate, commit, then flush overrides everything.
    always_comb begin
        ent_d      = ent_q;
        head_d     = head_q;
        tail_d     = tail_q;
        flush_d    = 1'b0;
        flush_pc_d = flush_pc_q;
        cmt_we_d   = 1'b0;
        cmt_rd_d   = cmt_rd_q;
        cmt_val_d  = cmt_val_q;
        cmt_tag_d  = cmt_tag_q;
        alloc_fire = 1'b0;
        retire     = 1'b0;
        mispredict = 1'b0;

        if (rdy) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (upd_hit[i] && ent_q[i].busy && !ent_q[i].done && !flush_q) begin
                    ent_d[i].val  = upd_val[i];
                    ent_d[i].npc  = upd_npc[i];
                    ent_d[i].done = 1'b1;
                end
            end

            alloc_fire = bus.alloc_valid && alloc_ready;
            if (alloc_fire) begin
                ent_d[tail_idx].busy     = 1'b1;
                ent_d[tail_idx].kind     = rob_kind_e'(bus.alloc_kind);
                ent_d[tail_idx].done     = bus.alloc_done || (rob_kind_e'(bus.alloc_kind) == ROB_KIND_STORE);
                ent_d[tail_idx].rd       = bus.alloc_rd;
                ent_d[tail_idx].val      = bus.alloc_val;
                // Pre-resolved entries never mispredict.
                ent_d[tail_idx].npc      = bus.alloc_pred_npc;
                ent_d[tail_idx].pred_npc = bus.alloc_pred_npc;
                tail_d = tail_q + 1'b1;
            end

            if (!empty && head_ent.done) begin
                if (head_ent.kind == ROB_KIND_STORE) begin
                    retire = bus.cmt_store_ack;
                end else begin
                    retire = 1'b1;
                    if (head_ent.kind != ROB_KIND_BRANCH) begin
                        cmt_we_d  = (head_ent.rd != 5'd0);
                        cmt_rd_d  = head_ent.rd;
                        cmt_val_d = head_ent.val;
                        cmt_tag_d = head_idx;
                    end
                    if (head_ent.kind != ROB_KIND_REG) begin
                        mispredict = (head_ent.npc != head_ent.pred_npc);
                    end
                end
            end

            if (retire) begin
                ent_d[head_idx].busy = 1'b0;
                ent_d[head_idx].done = 1'b0;
                head_d = head_q + 1'b1;
            end

            if (mispredict) begin
                flush_d    = 1'b1;
                flush_pc_d = head_ent.npc;
                for (int i = 0; i < DEPTH; i++) begin
                    ent_d[i].busy = 1'b0;
                    ent_d[i].done = 1'b0;
                end
                head_d = '0;
                tail_d = '0;
            end
        end
    end

    // State registers; reset discards every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the entry array is reset as a whole so busy/done start clear and queries never return X payload.
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            head_q     <= '0;
            tail_q     <= '0;
            flush_q    <= 1'b0;
            flush_pc_q <= '0;
            cmt_we_q   <= 1'b0;
            cmt_rd_q   <= '0;
            cmt_val_q  <= '0;
            cmt_tag_q  <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the same pre-edge values.
            ent_q      <= ent_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            flush_q    <= flush_d;
            flush_pc_q <= flush_pc_d;
            cmt_we_q   <= cmt_we_d;
            cmt_rd_q   <= cmt_rd_d;
            cmt_val_q  <= cmt_val_d;
            cmt_tag_q  <= cmt_tag_d;
        end
    end

    assign bus.alloc_ready   = alloc_ready;
    assign bus.alloc_tag     = tail_idx;
    assign bus.count         = count;
    assign bus.flush         = flush_q;
    assign bus.flush_pc      = flush_pc_q;
    assign bus.cmt_we        = cmt_we_q;
    assign bus.cmt_rd        = cmt_rd_q;
    assign bus.cmt_val       = cmt_val_q;
    assign bus.cmt_tag       = cmt_tag_q;
    assign bus.cmt_store     = cmt_store;
    assign bus.cmt_store_tag = head_idx;

    // Operand queries: same-cycle writeback first, then the stored value.
    assign bus.qa_ready = upd_hit[bus.qa_tag] || ent_q[bus.qa_tag].done;
    assign bus.qb_ready = upd_hit[bus.qb_tag] || ent_q[bus.qb_tag].done;
    assign bus.qa_val   = upd_hit[bus.qa_tag] ? upd_val[bus.qa_tag] :
                          ent_q[bus.qa_tag].done ? ent_q[bus.qa_tag].val : '0;
    assign bus.qb_val   = upd_hit[bus.qb_tag] ? upd_val[bus.qb_tag] :
                          ent_q[bus.qb_tag].done ? ent_q[bus.qb_tag].val : '0;

endmodule

// File: tb/tb_rob_gen2.sv
// Directed bench for rob_gen2 (DEPTH=16, NUM_WB=2, XLEN=32).
module tb_rob_gen2;
    import rob_pkg::*;

    logic clk;
    logic rst_n;
    logic rdy;
    int   n_checks = 0;
    int   n_fail   = 0;

    rob_gen2_if #(.IDX_W(4), .XLEN(32), .NUM_WB(2)) bus ();

    rob_gen2 #(.DEPTH(16), .XLEN(32), .NUM_WB(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rdy   (rdy),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [1:0]  kind;
        logic [4:0]  rd;
        logic [31:0] val;
        logic [31:0] pred;
        logic        exp_we;
        logic [31:0] exp_val;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alloc_valid    = 1'b0;
        bus.alloc_kind     = 2'd0;
        bus.alloc_rd       = 5'd0;
        bus.alloc_done     = 1'b0;
        bus.alloc_val      = '0;
        bus.alloc_pred_npc = '0;
        bus.wb_valid       = '0;
        bus.wb_tag         = '0;
        bus.wb_val         = '0;
        bus.wb_npc         = '0;
        bus.qa_tag         = '0;
        bus.qb_tag         = '0;
        bus.cmt_store_ack  = 1'b0;
    endtask

    task automatic set_alloc(input logic [1:0] kind, input logic [4:0] rd, input logic done,
                             input logic [31:0] val, input logic [31:0] pred);
        bus.alloc_valid    = 1'b1;
        bus.alloc_kind     = kind;
        bus.alloc_rd       = rd;
        bus.alloc_done     = done;
        bus.alloc_val      = val;
        bus.alloc_pred_npc = pred;
    endtask

    task automatic set_wb(input int port, input logic [3:0] tag, input logic [31:0] val,
                          input logic [31:0] npc);
        bus.wb_valid[port]         = 1'b1;
        bus.wb_tag[port*4 +: 4]    = tag;
        bus.wb_val[port*32 +: 32]  = val;
        bus.wb_npc[port*32 +: 32]  = npc;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0] = '{ROB_KIND_REG,    5'd5,  32'hDEADBEEF, 32'h0,   1'b1, 32'hDEADBEEF};
        vecs[1] = '{ROB_KIND_REG,    5'd0,  32'h00001234, 32'h0,   1'b0, 32'h0};
        vecs[2] = '{ROB_KIND_JALR,   5'd1,  32'h00000108, 32'h500, 1'b1, 32'h00000108};
        vecs[3] = '{ROB_KIND_BRANCH, 5'd0,  32'h0,        32'h600, 1'b0, 32'h0};
        vecs[4] = '{ROB_KIND_REG,    5'd31, 32'hFFFFFFFF, 32'h0,   1'b1, 32'hFFFFFFFF};

        idle();
        rdy   = 1'b1;
        rst_n = 1'b0;
        #1;
        // Reset state
        check("rst_alloc_ready", bus.alloc_ready, 1);
        check("rst_count",       bus.count, 0);
        check("rst_alloc_tag",   bus.alloc_tag, 0);
        check("rst_cmt_we",      bus.cmt_we, 0);
        check("rst_cmt_store",   bus.cmt_store, 0);
        check("rst_flush",       bus.flush, 0);
        check("rst_qa_ready",    bus.qa_ready, 0);
        tick();
        tick();
        rst_n = 1'b1;

        // Fill all 16 entries, none done
        for (int i = 0; i < 16; i++) begin
            set_alloc(ROB_KIND_REG, 5'(i + 1), 1'b0, 32'h0, 32'h0);
            check("fill_alloc_tag", bus.alloc_tag, 64'(i));
            tick();
        end
        check("full_count", bus.count, 16);
        check("full_alloc_ready", bus.alloc_ready, 0);
        tick();
        check("full_alloc_blocked", bus.count, 16);
        idle();
        set_wb(0, 4'd0, 32'h55, 32'h0);
        tick();
        idle();
        check("full_no_commit_on_done_edge", bus.cmt_we, 0);
        tick();
        check("full_cmt_we",  bus.cmt_we, 1);
        check("full_cmt_val", bus.cmt_val, 32'h55);
        check("full_cmt_tag", bus.cmt_tag, 0);
        check("full_cmt_rd",  bus.cmt_rd, 1);
        check("full_count15", bus.count, 15);
        check("full_alloc_ready_again", bus.alloc_ready, 1);
        do_reset();

        // Same-tag writeback collision and query bypass
        for (int i = 0; i < 4; i++) begin
            set_alloc(ROB_KIND_REG, 5'(i + 8), 1'b0, 32'h0, 32'h0);
            tick();
        end
        idle();
        set_wb(0, 4'd3, 32'h11, 32'h0);
        set_wb(1, 4'd3, 32'h22, 32'h0);
        bus.qa_tag = 4'd3;
        bus.qb_tag = 4'd2;
        #1;
        check("coll_qa_ready_bypass", bus.qa_ready, 1);
        check("coll_qa_val_bypass",   bus.qa_val, 32'h22);
        check("coll_qb_ready",        bus.qb_ready, 0);
        check("coll_qb_val",          bus.qb_val, 0);
        tick();
        bus.wb_valid = '0;
        #1;
        check("coll_qa_ready_stored", bus.qa_ready, 1);
        check("coll_qa_val_stored",   bus.qa_val, 32'h22);
        set_wb(0, 4'd2, 32'h33, 32'h0);
        #1;
        check("port0_bypass_val", bus.qb_val, 32'h33);
        tick();
        idle();
        set_wb(1, 4'd9, 32'h99, 32'h0);
        tick();
        idle();
        bus.qa_tag = 4'd9;
        #1;
        check("wb_nonbusy_ignored", bus.qa_ready, 0);
        check("coll_head_blocks_commit", bus.cmt_we, 0);
        check("coll_count", bus.count, 4);
        do_reset();

        // Store at head with delayed ack
        set_alloc(ROB_KIND_STORE, 5'd0, 1'b0, 32'h0, 32'h0);
        tick();
        check("st_cmt_store_early", bus.cmt_store, 1);
        set_alloc(ROB_KIND_REG, 5'd2, 1'b1, 32'h77, 32'h0);
        tick();
        idle();
        for (int k = 0; k < 5; k++) begin
            check("st_wait_store", bus.cmt_store, 1);
            check("st_wait_no_we", bus.cmt_we, 0);
            tick();
        end
        check("st_store_tag", bus.cmt_store_tag, 0);
        check("st_count_wait", bus.count, 2);
        bus.cmt_store_ack = 1'b1;
        tick();
        bus.cmt_store_ack = 1'b0;
        check("st_store_retired", bus.cmt_store, 0);
        check("st_no_we_for_store", bus.cmt_we, 0);
        check("st_count_after_ack", bus.count, 1);
        tick();
        check("st_reg_cmt_we",  bus.cmt_we, 1);
        check("st_reg_cmt_rd",  bus.cmt_rd, 2);
        check("st_reg_cmt_val", bus.cmt_val, 32'h77);
        check("st_count_empty", bus.count, 0);

        // Branch mispredict with three younger entries
        check("br_alloc_tag", bus.alloc_tag, 2);
        set_alloc(ROB_KIND_BRANCH, 5'd0, 1'b0, 32'h0, 32'h1004);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_alloc(ROB_KIND_REG, 5'(i + 3), 1'b1, 32'(i + 32'h40), 32'h0);
            tick();
        end
        idle();
        check("br_count_before", bus.count, 4);
        set_wb(1, 4'd2, 32'h0, 32'h2000);
        tick();
        idle();
        check("br_no_flush_on_done_edge", bus.flush, 0);
        tick();
        check("br_flush",       bus.flush, 1);
        check("br_flush_pc",    bus.flush_pc, 32'h2000);
        check("br_count_zero",  bus.count, 0);
        check("br_alloc_ready", bus.alloc_ready, 0);
        check("br_no_we",       bus.cmt_we, 0);
        check("br_tail_reset",  bus.alloc_tag, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("br_younger_never_commit", bus.cmt_we, 0);
            check("br_flush_one_cycle", bus.flush, 0);
        end
        check("br_alloc_ready_after", bus.alloc_ready, 1);

        // JALR correctly predicted, then JALR mispredicted
        set_alloc(ROB_KIND_JALR, 5'd1, 1'b0, 32'h0, 32'h200);
        tick();
        idle();
        set_wb(0, 4'd0, 32'h108, 32'h200);
        tick();
        idle();
        check("jalr_wait", bus.cmt_we, 0);
        tick();
        check("jalr_cmt_we",  bus.cmt_we, 1);
        check("jalr_cmt_val", bus.cmt_val, 32'h108);
        check("jalr_cmt_rd",  bus.cmt_rd, 1);
        check("jalr_no_flush", bus.flush, 0);
        set_alloc(ROB_KIND_JALR, 5'd7, 1'b0, 32'h0, 32'h300);
        tick();
        idle();
        set_wb(1, 4'd1, 32'h10C, 32'h400);
        tick();
        idle();
        tick();
        check("jalr_mp_cmt_we",   bus.cmt_we, 1);
        check("jalr_mp_cmt_val",  bus.cmt_val, 32'h10C);
        check("jalr_mp_cmt_tag",  bus.cmt_tag, 1);
        check("jalr_mp_flush",    bus.flush, 1);
        check("jalr_mp_flush_pc", bus.flush_pc, 32'h400);
        tick();
        check("jalr_mp_flush_drop", bus.flush, 0);

        // Table: pre-resolved entries of each kind
        for (int v = 0; v < 5; v++) begin
            set_alloc(vecs[v].kind, vecs[v].rd, 1'b1, vecs[v].val, vecs[v].pred);
            tick();
            idle();
            tick();
            check("vec_cmt_we", bus.cmt_we, vecs[v].exp_we);
            if (vecs[v].exp_we) begin
                check("vec_cmt_val", bus.cmt_val, vecs[v].exp_val);
                check("vec_cmt_rd",  bus.cmt_rd, vecs[v].rd);
            end
            check("vec_no_flush", bus.flush, 0);
            check("vec_count",    bus.count, 0);
        end

        // rdy=0 stalls allocation and commit
        set_alloc(ROB_KIND_REG, 5'd6, 1'b1, 32'hAB, 32'h0);
        rdy = 1'b0;
        tick();
        check("stall_no_alloc", bus.count, 0);
        rdy = 1'b1;
        tick();
        idle();
        check("stall_alloc_count", bus.count, 1);
        check("stall_no_we_yet", bus.cmt_we, 0);
        rdy = 1'b0;
        tick();
        check("stall_no_commit", bus.cmt_we, 0);
        check("stall_count_hold", bus.count, 1);
        rdy = 1'b1;
        tick();
        check("stall_commit_we",  bus.cmt_we, 1);
        check("stall_commit_val", bus.cmt_val, 32'hAB);
        check("stall_count_zero", bus.count, 0);

        // Tail wrap: back-to-back alloc/commit pairs
        do_reset();
        for (int k = 0; k <= 40; k++) begin
            if (k < 40) set_alloc(ROB_KIND_REG, 5'((k % 31) + 1), 1'b1, 32'(k * 3 + 1), 32'h0);
            else idle();
            tick();
            if (k > 0) begin
                check("wrap_cmt_we",  bus.cmt_we, 1);
                check("wrap_cmt_tag", bus.cmt_tag, 64'((k - 1) % 16));
                check("wrap_cmt_val", bus.cmt_val, 64'((k - 1) * 3 + 1));
            end
            check("wrap_count", bus.count, (k < 40) ? 1 : 0);
        end

        // Asynchronous reset in mid-stream
        for (int k = 0; k < 5; k++) begin
            set_alloc(ROB_KIND_REG, 5'd3, 1'b1, 32'(k + 100), 32'h0);
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_cmt_we",      bus.cmt_we, 0);
        check("arst_cmt_val",     bus.cmt_val, 0);
        check("arst_cmt_tag",     bus.cmt_tag, 0);
        check("arst_count",       bus.count, 0);
        check("arst_alloc_tag",   bus.alloc_tag, 0);
        check("arst_alloc_ready", bus.alloc_ready, 1);
        check("arst_flush",       bus.flush, 0);
        idle();
        tick();
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
